// File: rtl/fm_modulator.sv
// Audio-to-baseband FM modulator: scaled audio steers a phase accumulator whose
// phase is turned into signed 12-bit I/Q through a folded quarter-wave sine table.
module fm_modulator #(
  parameter int PHASE_W    = 24,
  parameter int CENTER_INC = 0,
  parameter int DEV_SHIFT  = 4,
  parameter int LUT_AW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] audio_in,
  input  logic        audio_valid,
  input  logic        mute,
  output logic [11:0] I_out,
  output logic [11:0] Q_out,
  output logic        out_valid
);

  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int P_W       = LUT_AW + 2;
  localparam logic [PHASE_W-1:0] CENTER_INC_W = PHASE_W'(CENTER_INC);

  // The half-step angle offset makes ~a map exactly onto the mirrored quadrant.
  function automatic logic [LUT_DEPTH*11-1:0] build_table();
    logic [LUT_DEPTH*11-1:0] t;
    real x;
    t = '0;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      x = 2047.0 * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(LUT_DEPTH));
      t[k*11 +: 11] = 11'($rtoi(x + 0.5));
    end
    return t;
  endfunction

  localparam logic [LUT_DEPTH*11-1:0] SINE_TABLE = build_table();

  function automatic logic [10:0] lut_mag(input logic [P_W-1:0] p);
    logic [LUT_AW-1:0] a;
    logic [LUT_AW-1:0] idx;
    a = p[LUT_AW-1:0];
    if (p[LUT_AW]) begin
      idx = ~a;
    end else begin
      idx = a;
    end
    return SINE_TABLE[int'(idx)*11 +: 11];
  endfunction

  logic [PHASE_W-1:0] inc_d, inc_q;
  logic [PHASE_W-1:0] phase_d, phase_q;
  logic               v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [10:0]        sin_mag_d, sin_mag_q, cos_mag_d, cos_mag_q;
  logic               sin_neg_d, sin_neg_q, cos_neg_d, cos_neg_q;
  logic [11:0]        i_out_d, i_out_q, q_out_d, q_out_q;
  logic               out_valid_d, out_valid_q;

  logic [11:0]        audio_eff;
  logic [PHASE_W-1:0] audio_ext;
  logic [P_W-1:0]     p_sin, p_cos;
  logic               unused_phase_lsbs;

  assign unused_phase_lsbs = ^phase_q[PHASE_W-P_W-1:0];

  // Stage 1 and 2: form the per-sample increment, then advance the phase.
  always_comb begin
    if (mute) begin
      audio_eff = 12'd0;
    end else begin
      audio_eff = audio_in;
    end
    audio_ext = {{(PHASE_W-12){audio_eff[11]}}, audio_eff};
    if (audio_valid) begin
      inc_d = CENTER_INC_W + (audio_ext << DEV_SHIFT);
    end else begin
      inc_d = inc_q;
    end
    v1_d = audio_valid;
    if (v1_q) begin
      phase_d = phase_q + inc_q;
    end else begin
      phase_d = phase_q;
    end
    v2_d = v1_q;
  end

  // Stage 3 and 4: quadrant fold with registered table read, then signed outputs.
  always_comb begin
    p_sin     = phase_q[PHASE_W-1 -: P_W];
    p_cos     = p_sin + P_W'(LUT_DEPTH);
    sin_mag_d = lut_mag(p_sin);
    cos_mag_d = lut_mag(p_cos);
    sin_neg_d = p_sin[P_W-1];
    cos_neg_d = p_cos[P_W-1];
    v3_d      = v2_q;
    if (v3_q) begin
      if (cos_neg_q) begin
        i_out_d = 12'd0 - {1'b0, cos_mag_q};
      end else begin
        i_out_d = {1'b0, cos_mag_q};
      end
      if (sin_neg_q) begin
        q_out_d = 12'd0 - {1'b0, sin_mag_q};
      end else begin
        q_out_d = {1'b0, sin_mag_q};
      end
    end else begin
      i_out_d = i_out_q;
      q_out_d = q_out_q;
    end
    out_valid_d = v3_q;
  end

  // Pipeline state; reset discards everything in flight and restarts the phase at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q       <= '0;
      phase_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      sin_mag_q   <= 11'd0;
      cos_mag_q   <= 11'd0;
      sin_neg_q   <= 1'b0;
      cos_neg_q   <= 1'b0;
      i_out_q     <= 12'd0;
      q_out_q     <= 12'd0;
      out_valid_q <= 1'b0;
    end else begin
      inc_q       <= inc_d;
      phase_q     <= phase_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      sin_mag_q   <= sin_mag_d;
      cos_mag_q   <= cos_mag_d;
      sin_neg_q   <= sin_neg_d;
      cos_neg_q   <= cos_neg_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign I_out     = i_out_q;
  assign Q_out     = q_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fm_modulator.sv
// Self-checking bench: two modulators (carrier 2^22 and 0) share one random audio
// stream and are compared against a trig-based phase model every cycle.
module tb_fm_modulator;

  typedef struct { int due; int i; int q; } exp_t;
  typedef struct { int i; int q; } iq_t;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] audio_in;
  logic        audio_valid;
  logic        mute;
  logic [11:0] i_o [2];
  logic [11:0] q_o [2];
  logic        out_v [2];

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  longint center [2] = '{64'd4194304, 64'd0};
  longint phase [2];
  int     held_i [2];
  int     held_q [2];
  int     pulses [2];
  exp_t   eq [2][$];
  iq_t    dq [2][$];

  fm_modulator #(.PHASE_W(24), .CENTER_INC(4194304), .DEV_SHIFT(4), .LUT_AW(8)) dut_a (
    .clk(clk), .rst(rst), .audio_in(audio_in), .audio_valid(audio_valid), .mute(mute),
    .I_out(i_o[0]), .Q_out(q_o[0]), .out_valid(out_v[0])
  );

  fm_modulator #(.PHASE_W(24), .CENTER_INC(0), .DEV_SHIFT(4), .LUT_AW(8)) dut_b (
    .clk(clk), .rst(rst), .audio_in(audio_in), .audio_valid(audio_valid), .mute(mute),
    .I_out(i_o[1]), .Q_out(q_o[1]), .out_valid(out_v[1])
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // Ideal carrier sampled at the centre of the table cell the phase falls into.
  function automatic iq_t expect_iq(input longint ph);
    iq_t r;
    real ang;
    ang = 2.0 * PI * (real'(ph >> 14) + 0.5) / 1024.0;
    r.i = rnd(2047.0 * $cos(ang));
    r.q = rnd(2047.0 * $sin(ang));
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      eq[d].delete();
      phase[d] = 0;
      held_i[d] = 0;
      held_q[d] = 0;
    end
  endtask

  task automatic push_quarter();
    dq[0].push_back('{-6, 2047});
    dq[0].push_back('{-2047, -6});
    dq[0].push_back('{6, -2047});
    dq[0].push_back('{2047, 6});
  endtask

  task automatic tick(input logic v, input int a, input logic m);
    exp_t e;
    iq_t  r;
    iq_t  dx;
    audio_valid = v;
    audio_in    = 12'(a);
    mute        = m;
    @(posedge clk);
    cyc++;
    if (v) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = (phase[d] + center[d] + longint'(m ? 0 : a * 16)) & 64'hFFFFFF;
        r = expect_iq(phase[d]);
        e.due = cyc + 3;
        e.i = r.i;
        e.q = r.q;
        eq[d].push_back(e);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic ev;
      ev = (eq[d].size() > 0) && (eq[d][0].due == cyc);
      check_eq($sformatf("valid%0d", d), int'(out_v[d]), int'(ev));
      if (ev) begin
        e = eq[d].pop_front();
        held_i[d] = e.i;
        held_q[d] = e.q;
      end
      if (out_v[d]) begin
        pulses[d]++;
        if (dq[d].size() > 0) begin
          dx = dq[d].pop_front();
          check_eq($sformatf("dir_I%0d", d), int'($signed(i_o[d])), dx.i);
          check_eq($sformatf("dir_Q%0d", d), int'($signed(q_o[d])), dx.q);
        end
      end
      check_eq($sformatf("I%0d", d), int'($signed(i_o[d])), held_i[d]);
      check_eq($sformatf("Q%0d", d), int'($signed(q_o[d])), held_q[d]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 0, 1'b0);
  endtask

  // Called at a falling edge; reset lands mid-cycle so its effect must be asynchronous.
  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_valid%0d", d), int'(out_v[d]), 0);
      check_eq($sformatf("rst_I%0d", d), int'($signed(i_o[d])), 0);
      check_eq($sformatf("rst_Q%0d", d), int'($signed(q_o[d])), 0);
    end
    model_clear();
    @(negedge clk);
    audio_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int a;
    rst = 1'b1;
    audio_valid = 1'b0;
    audio_in = 12'd0;
    mute = 1'b0;
    pulses[0] = 0;
    pulses[1] = 0;
    model_clear();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("init_valid%0d", d), int'(out_v[d]), 0);
      check_eq($sformatf("init_I%0d", d), int'($signed(i_o[d])), 0);
    end
    rst = 1'b0;
    idle(3);

    push_quarter();
    for (int k = 0; k < 4; k++) tick(1'b1, 0, 1'b0);
    idle(4);

    tick(1'b1, 100, 1'b0);
    tick(1'b1, -300, 1'b0);
    reset_mid();
    idle(5);

    dq[1].push_back('{2047, 19});
    tick(1'b1, 1024, 1'b0);
    idle(4);

    reset_mid();
    dq[1].push_back('{2047, -19});
    tick(1'b1, -2048, 1'b0);
    idle(4);

    reset_mid();
    push_quarter();
    for (int k = 0; k < 4; k++) tick(1'b1, 2047, 1'b1);
    idle(4);

    pulses[0] = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, int'($urandom_range(0, 4095)) - 2048, 1'b0);
      idle(2);
    end
    idle(4);
    check_eq("gap_pulses", pulses[0], 5);

    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0: a = -2048;
        1: a = 2047;
        default: a = int'($urandom_range(0, 4095)) - 2048;
      endcase
      tick($urandom_range(0, 99) < 65, a, $urandom_range(0, 9) == 0);
      if (k == 300) reset_mid();
    end
    idle(4);
    check_eq("dir_left_a", dq[0].size(), 0);
    check_eq("dir_left_b", dq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fm_modulator.md
Name: fm_modulator

Overview:
- Audio-to-baseband FM modulator; the transmit counterpart of the FM demodulator.
- Takes signed 12-bit audio samples and advances a phase accumulator by a centre increment plus scaled audio.
- Converts the phase to I/Q through a quarter-wave sine table with symmetry folding.
- Emits signed 12-bit I/Q samples at the input sample rate, for the upconversion/DAC path or for loopback into the FM demodulator.

Parameters:
PHASE_W, 24, phase accumulator width; one full turn = 2^PHASE_W.
CENTER_INC, 0, signed carrier/offset phase increment per sample, taken modulo 2^PHASE_W.
DEV_SHIFT, 4, left shift applied to audio to form the frequency deviation increment.
LUT_AW, 8, quarter-wave table address width; depth is 2^LUT_AW.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous active-high reset.
audio_in  input  12  signed audio sample; sampled only when audio_valid=1.
audio_valid  input  1  single-cycle sample strobe; may be high on consecutive cycles.
mute  input  1  when 1, the accepted sample is treated as 0 (unmodulated carrier); sampled together with audio_valid.
I_out  output  12  signed cosine output.
Q_out  output  12  signed sine output.
out_valid  output  1  high for one cycle per produced I/Q pair.

Behaviour:
- Reset (async, active-high): phase accumulator, all pipeline registers, I_out, Q_out and out_valid all go to 0. In-flight samples are discarded. The first sample accepted after reset release starts from phase 0.
- Stage 1 (cycle N+1 after audio_valid at cycle N):
  - inc = CENTER_INC + (sign-extended audio << DEV_SHIFT), computed modulo 2^PHASE_W.
  - If mute=1, audio is taken as 0.
  - Negative inc is legal (frequency below centre).
- Stage 2 (N+2): phase <= phase + inc, modulo 2^PHASE_W, natural wrap with no saturation. The phase advances only for accepted samples; it holds when no sample arrives.
- Stage 3 (N+3): fold phase into quadrant and table address.
  - Let p = top (2+LUT_AW) bits of the new phase, q = top 2 bits, a = lower LUT_AW bits.
  - Sine: magnitude = T[q[0] ? ~a : a]; negative if q[1]=1.
  - Cosine: apply the same rule to p + 2^LUT_AW (one quadrant ahead).
  - Table read is registered. The sign flags are pipelined alongside.
- Stage 4 (N+4): I_out/Q_out <= signed result (negate when the flag is set); out_valid=1 for exactly one cycle.
  - Total latency is 4 cycles.
  - Throughput is one sample per clock.
  - Outputs hold their last value while out_valid=0.
- Table contents: T[k] = round(2047*sin(pi/2*(k+0.5)/2^LUT_AW)), for k = 0..2^LUT_AW-1.
  - The half-step offset makes bit-inversion folding exact.
  - Values lie in 0..2047, so negation never overflows 12 bits.
  - For LUT_AW=8: T[0]=6, T[255]=2047.
- Ordering of outputs:
  - The output for sample n always reflects the phase after sample n's increment is added.
  - Back-to-back strobes produce back-to-back out_valid in the same order.
  - Gaps in audio_valid are reproduced as identical gaps in out_valid.
- Boundaries:
  - audio_in = -2048 with DEV_SHIFT=4 gives an increment contribution of -32768, correctly sign-extended.
  - Phase wrap from 2^PHASE_W-1 to 0 produces no output glitch.
  - mute toggling affects only samples strobed while it is high.
  - rst asserted mid-stream clears out_valid immediately (asynchronously); no output is produced for pre-reset samples.

Test Plan:
- Reset: assert rst with out_valid pending -> I_out=0, Q_out=0, out_valid=0 immediately; after release with no strobes, outputs stay 0.
- Quarter-turn carrier (CENTER_INC=2^22, audio=0, 4 consecutive strobes):
  - out_valid starts 4 cycles after the first strobe.
  - (I,Q) sequence = (-6,2047), (-2047,-6), (6,-2047), (2047,6).
- Deviation (CENTER_INC=0, audio=+1024, DEV_SHIFT=4, one strobe) -> phase=16384, p=1, I=2047, Q=T[1]=19.
- Negative audio and wrap (CENTER_INC=0, audio=-2048, one strobe from phase 0) -> phase=2^24-32768, p=1022, q=3, a=254.
  - Sine: T[1] negated -> Q=-19.
  - Cosine: wraps to q=0, a=254 -> I=T[254]=2047.
- Mute: CENTER_INC=2^22, audio=+2047, mute=1 -> output identical to the audio=0 case.
- Gapped strobes (strobe every 3 cycles, 5 samples) -> exactly 5 out_valid pulses spaced 3 cycles apart, each 4 cycles after its strobe; phase does not advance between strobes.
